// File: rtl/ex_alu_stage.sv
// Execute-stage ALU and EX/MEM pipeline register of the MIPS core, with a combinational forwarding tap.
// Optional build macro ALU_OVF_TRAP_EN: a valid signed overflow raises o_ovf_trap and suppresses writeback.
module ex_alu_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [3:0]        i_aluconf,
  input  logic              i_sign,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [REG_W-1:0]  i_shamt,
  input  logic              i_valid,
  input  logic [REG_W-1:0]  i_rd,
  input  logic              i_regwrite,
  input  logic              i_memread,
  input  logic              i_memwrite,
  input  logic [DATA_W-1:0] i_store_data,
  input  logic              i_stall,
  input  logic              i_flush,
  output logic [DATA_W-1:0] o_fwd_result,
  output logic [DATA_W-1:0] o_result,
  output logic              o_zero,
  output logic              o_valid,
  output logic [REG_W-1:0]  o_rd,
  output logic              o_regwrite,
  output logic              o_memread,
  output logic              o_memwrite,
  output logic [DATA_W-1:0] o_store_data,
  output logic              o_ovf_trap
);

  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_ADD = 4'd2,
    ALU_SUB = 4'd3,
    ALU_SLT = 4'd4,
    ALU_NOR = 4'd5,
    ALU_XOR = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic              zero;
    logic              valid;
    logic [REG_W-1:0]  rd;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic [DATA_W-1:0] store_data;
    logic              ovf_trap;
  } exmem_t;

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [4:0]        shamt;
  logic              lt;
  logic [DATA_W-1:0] alu_res;
  logic              trap;
  exmem_t            exmem_d;
  exmem_t            exmem_q;

  assign sum   = i_a + i_b;
  assign diff  = i_a - i_b;
  assign shamt = i_shamt[4:0];
  assign lt    = i_sign ? ($signed(i_a) < $signed(i_b)) : (i_a < i_b);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    alu_res = '0;
    case (i_aluconf)
      ALU_AND: alu_res = i_a & i_b;
      ALU_OR:  alu_res = i_a | i_b;
      ALU_ADD: alu_res = sum;
      ALU_SUB: alu_res = diff;
      ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, lt};
      ALU_NOR: alu_res = ~(i_a | i_b);
      ALU_XOR: alu_res = i_a ^ i_b;
      ALU_SLL: alu_res = i_b << shamt;
      ALU_SRL: alu_res = i_b >> shamt;
      ALU_SRA: alu_res = $signed(i_b) >>> shamt;
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_OVF_TRAP_EN
  logic ovf;

  always_comb begin
    ovf = 1'b0;
    if (i_sign) begin
      if (i_aluconf == ALU_ADD)
        ovf = (i_a[MSB] == i_b[MSB]) && (sum[MSB] != i_a[MSB]);
      else if (i_aluconf == ALU_SUB)
        ovf = (i_a[MSB] != i_b[MSB]) && (diff[MSB] != i_a[MSB]);
    end
  end

  assign trap = ovf & i_valid;
`else
  assign trap = 1'b0;
`endif

  // Enables are qualified by valid so a bubble slot can never write.
  always_comb begin
    exmem_d            = '0;
    exmem_d.result     = alu_res;
    exmem_d.zero       = (alu_res == '0);
    exmem_d.valid      = i_valid;
    exmem_d.rd         = i_rd;
    exmem_d.regwrite   = i_regwrite & i_valid & ~trap;
    exmem_d.memread    = i_memread & i_valid;
    exmem_d.memwrite   = i_memwrite & i_valid;
    exmem_d.store_data = i_store_data;
    exmem_d.ovf_trap   = trap;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush)
      exmem_q <= '0;
    else if (!i_stall)
      exmem_q <= exmem_d;
  end

  assign o_fwd_result = alu_res;
  assign o_result     = exmem_q.result;
  assign o_zero       = exmem_q.zero;
  assign o_valid      = exmem_q.valid;
  assign o_rd         = exmem_q.rd;
  assign o_regwrite   = exmem_q.regwrite;
  assign o_memread    = exmem_q.memread;
  assign o_memwrite   = exmem_q.memwrite;
  assign o_store_data = exmem_q.store_data;
  assign o_ovf_trap   = exmem_q.ovf_trap;

endmodule
